cs5343_i2s_rx: RTL and testbench

// - Capture side of the Cirrus CS5343 ADC link in dafx_core. Generates cs_rx_mclk, cs_rx_sclk and cs_rx_lrck.
// - Deserialises I2S data from cs_rx_sdin into 24-bit stereo sample pairs.
// - Presents each pair on a valid/ready stream for the effects pipeline.
// - Complement of the cs_tx (DAC) serializer, which consumes the same frame format.

---
 rtl/dafx_pkg.sv | 19 +
 rtl/cs5343_clkgen.sv | 75 +++++++
 rtl/cs5343_i2s_rx.sv | 84 ++++++++
 tb/tb_cs5343_i2s_rx.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dafx_pkg.sv
// Shared CS5343/CS4344 codec link types and frame geometry for dafx_core.
// Pure declarations, no logic.
package dafx_pkg;

    localparam int CS_SLOT_BITS_C    = 32;
    localparam int CS_FRAME_BITS_C   = 64;
    localparam int CS_SAMPLE_WIDTH_C = 24;

    typedef struct packed {
        logic [CS_SAMPLE_WIDTH_C-1:0] left;
        logic [CS_SAMPLE_WIDTH_C-1:0] right;
    } cs_stereo_t;

    typedef enum logic {
        CS_IDLE = 1'b0,
        CS_RUN  = 1'b1
    } cs_clk_state_e;

endpackage

// File: rtl/cs5343_clkgen.sv
// Codec clock generator: MCLK = clk/2, SCLK/LRCK frame timing and a per-bit sample strobe.
// Latency: outputs registered; the first en=1 edge starts the frame at b=0 (LRCK falls).
// Backpressure: none, free-running while en=1.
module cs5343_clkgen
    import dafx_pkg::*;
#(
    parameter int SCLK_HALF_P = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       mclk,
    output logic       sclk,
    output logic       lrck,
    output logic       sample_stb,
    output logic [5:0] bit_idx
);

    localparam int PW = $clog2(2 * SCLK_HALF_P);
    localparam logic [PW-1:0] P_LAST = PW'(2 * SCLK_HALF_P - 1);
    localparam logic [PW-1:0] P_HIGH = PW'(SCLK_HALF_P);

    cs_clk_state_e   state, state_nxt;
    logic [PW-1:0]   phase, phase_nxt;
    logic [5:0]      bit_cnt, bit_nxt;
    logic            sclk_nxt, lrck_nxt;

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        bit_nxt   = bit_cnt;
        case (state)
            CS_IDLE: if (en) state_nxt = CS_RUN;
            CS_RUN: begin
                if (!en) begin
                    state_nxt = CS_IDLE;
                    phase_nxt = '0;
                    bit_nxt   = '0;
                end else if (phase == P_LAST) begin
                    phase_nxt = '0;
                    bit_nxt   = bit_cnt + 6'd1;
                end else begin
                    phase_nxt = phase + PW'(1);
                end
            end
            default: state_nxt = CS_IDLE;
        endcase
        // Derived from next-state so the registered pins line up with the counters.
        sclk_nxt = (state_nxt == CS_RUN) && (phase_nxt >= P_HIGH);
        lrck_nxt = (state_nxt == CS_IDLE) || (bit_nxt >= 6'(CS_SLOT_BITS_C));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CS_IDLE;
            phase   <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            lrck    <= 1'b1;
            mclk    <= 1'b0;
        end else begin
            state   <= state_nxt;
            phase   <= phase_nxt;
            bit_cnt <= bit_nxt;
            sclk    <= sclk_nxt;
            lrck    <= lrck_nxt;
            mclk    <= ~mclk;
        end
    end

    // Last clk of the SCLK high phase, just before the ADC's falling-edge update.
    assign sample_stb = (state == CS_RUN) && en && (phase == P_LAST);
    assign bit_idx    = bit_cnt;

endmodule

// File: rtl/cs5343_i2s_rx.sv
// CS5343 I2S capture: deserialises 24-bit stereo pairs onto a valid/ready stream.
// Latency: pair presented on the edge that samples the right LSB (b=56).
// Backpressure: single output register; an unaccepted pair is overwritten and rx_overflow sticks.
module cs5343_i2s_rx
    import dafx_pkg::*;
#(
    parameter int SAMPLE_WIDTH_P = 24,
    parameter int SCLK_HALF_P    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    output logic                      cs_rx_mclk,
    output logic                      cs_rx_sclk,
    output logic                      cs_rx_lrck,
    input  logic                      cs_rx_sdin,
    output logic [SAMPLE_WIDTH_P-1:0] rx_left,
    output logic [SAMPLE_WIDTH_P-1:0] rx_right,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      rx_overflow,
    input  logic                      overflow_clr
);

    localparam logic [5:0] L_LAST  = 6'(SAMPLE_WIDTH_P);
    localparam logic [5:0] R_FIRST = 6'(CS_SLOT_BITS_C + 1);
    localparam logic [5:0] R_LAST  = 6'(CS_SLOT_BITS_C + SAMPLE_WIDTH_P);

    logic                      sample_stb;
    logic [5:0]                bit_idx;
    logic                      sdin_q;
    logic [SAMPLE_WIDTH_P-1:0] left_sr, right_sr;
    logic                      in_left, in_right, pair_land;

    cs5343_clkgen #(.SCLK_HALF_P(SCLK_HALF_P)) u_clkgen (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mclk       (cs_rx_mclk),
        .sclk       (cs_rx_sclk),
        .lrck       (cs_rx_lrck),
        .sample_stb (sample_stb),
        .bit_idx    (bit_idx)
    );

    // One-SCLK I2S delay: bit 0 of each slot is skipped.
    assign in_left   = (bit_idx >= 6'd1) && (bit_idx <= L_LAST);
    assign in_right  = (bit_idx >= R_FIRST) && (bit_idx <= R_LAST);
    assign pair_land = sample_stb && (bit_idx == R_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sdin_q      <= 1'b0;
            left_sr     <= '0;
            right_sr    <= '0;
            rx_left     <= '0;
            rx_right    <= '0;
            rx_valid    <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            sdin_q <= cs_rx_sdin;

            if (!en) begin
                left_sr  <= '0;
                right_sr <= '0;
            end else if (sample_stb) begin
                if (in_left)  left_sr  <= {left_sr[SAMPLE_WIDTH_P-2:0], sdin_q};
                if (in_right) right_sr <= {right_sr[SAMPLE_WIDTH_P-2:0], sdin_q};
            end

            if (pair_land) begin
                rx_left  <= left_sr;
                rx_right <= {right_sr[SAMPLE_WIDTH_P-2:0], sdin_q};
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (pair_land && rx_valid && !rx_ready) rx_overflow <= 1'b1;
            else if (overflow_clr)                  rx_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cs5343_i2s_rx.sv
// Self-checking bench for cs5343_i2s_rx: I2S ADC model feeding a pair scoreboard.
module tb_cs5343_i2s_rx;
    import dafx_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        cs_rx_sdin = 1'b0;
    logic        rx_ready = 1'b1;
    logic        overflow_clr = 1'b0;
    logic        cs_rx_mclk, cs_rx_sclk, cs_rx_lrck;
    logic [23:0] rx_left, rx_right;
    logic        rx_valid, rx_overflow;

    int          checks = 0;
    int          errors = 0;
    cs_stereo_t  tx_q[$];
    cs_stereo_t  exp_q[$];
    cs_stereo_t  model_last;
    int          fs_cnt = 0;
    int          done_cnt = 0;
    int          hs_count = 0;
    logic [23:0] last_hs_l = '0, last_hs_r = '0;

    cs5343_i2s_rx #(.SAMPLE_WIDTH_P(24), .SCLK_HALF_P(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cs_rx_mclk   (cs_rx_mclk),
        .cs_rx_sclk   (cs_rx_sclk),
        .cs_rx_lrck   (cs_rx_lrck),
        .cs_rx_sdin   (cs_rx_sdin),
        .rx_left      (rx_left),
        .rx_right     (rx_right),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_overflow  (rx_overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // ADC model: updates data after each SCLK fall, realigns on every LRCK change.
    task automatic adc_model;
        logic       m_lrck = 1'b1;
        logic       m_sclk = 1'b0;
        int         m_pos = 0;
        bit         pushed = 1'b0;
        cs_stereo_t cur = '0;
        forever begin
            @(posedge clk);
            #1;
            if (cs_rx_lrck !== m_lrck) begin
                m_pos  = 0;
                pushed = 1'b0;
                m_lrck = cs_rx_lrck;
                if (m_lrck == 1'b0) begin
                    if (tx_q.size() != 0) cur = tx_q.pop_front();
                    else begin
                        cur.left  = 24'($urandom);
                        cur.right = 24'($urandom);
                    end
                    fs_cnt++;
                end
            end else if (m_sclk && !cs_rx_sclk) begin
                m_pos++;
                if (m_lrck && m_pos == 24 && !pushed) begin
                    exp_q.push_back(cur);
                    model_last = cur;
                    pushed = 1'b1;
                    done_cnt++;
                end
            end
            m_sclk = cs_rx_sclk;
            if (m_pos >= 1 && m_pos <= 24)
                cs_rx_sdin = m_lrck ? cur.right[24-m_pos] : cur.left[24-m_pos];
            else
                cs_rx_sdin = 1'($urandom_range(1, 0));
        end
    endtask

    // Scoreboard: every completed handshake must match the oldest pair sent.
    task automatic monitor;
        cs_stereo_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && rx_valid === 1'b1 && rx_ready === 1'b1) begin
                hs_count++;
                last_hs_l = rx_left;
                last_hs_r = rx_right;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL hs_data: got %h/%h, expected no pair", rx_left, rx_right);
                end else begin
                    e = exp_q.pop_front();
                    if (rx_left !== e.left || rx_right !== e.right) begin
                        errors++;
                        $display("FAIL hs_data: got %h/%h, expected %h/%h",
                                 rx_left, rx_right, e.left, e.right);
                    end
                end
            end
        end
    endtask

    task automatic wait_done(input int n, output bit ok);
        int start = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < n * 700; i++) begin
            tick();
            if (done_cnt - start >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_fs(output bit ok);
        int start = fs_cnt;
        ok = 1'b0;
        for (int i = 0; i < 700; i++) begin
            tick();
            if (fs_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [6:0] got;
        rst = 1'b1;
        en  = 1'b0;
        tick();
        tick();
        got = {cs_rx_mclk, cs_rx_sclk, cs_rx_lrck, rx_valid, rx_overflow, |rx_left, |rx_right};
        checks++;
        if (got !== 7'b0010000) begin
            errors++;
            $display("FAIL reset_state: mclk,sclk,lrck,valid,ovf,|l,|r = %b, expected 0010000", got);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (cs_rx_mclk !== 1'b1) begin
            errors++;
            $display("FAIL mclk_first_toggle: got %b, expected 1", cs_rx_mclk);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (cs_rx_sclk !== 1'b0 || cs_rx_lrck !== 1'b1) begin
            errors++;
            $display("FAIL idle_clocks: sclk=%b lrck=%b, expected 0/1", cs_rx_sclk, cs_rx_lrck);
        end
    endtask

    task automatic test_clocks;
        int   bad_mclk = 0, bad_sclk = 0, bad_lrck = 0, bad_valid = 0;
        logic prev_mclk;
        prev_mclk = cs_rx_mclk;
        en = 1'b1;
        for (int k = 0; k < 1024; k++) begin
            tick();
            if (cs_rx_mclk === prev_mclk) bad_mclk++;
            prev_mclk = cs_rx_mclk;
            if (cs_rx_sclk !== ((k % 8) >= 4)) bad_sclk++;
            if (cs_rx_lrck !== (((k / 8) % 64) >= 32)) bad_lrck++;
            if (rx_valid !== (k == 456 || k == 968)) bad_valid++;
        end
        checks++;
        if (bad_mclk != 0) begin errors++; $display("FAIL mclk_period: %0d bad cycles, expected 0", bad_mclk); end
        checks++;
        if (bad_sclk != 0) begin errors++; $display("FAIL sclk_period: %0d bad cycles, expected 0", bad_sclk); end
        checks++;
        if (bad_lrck != 0) begin errors++; $display("FAIL lrck_period: %0d bad cycles, expected 0", bad_lrck); end
        checks++;
        if (bad_valid != 0) begin errors++; $display("FAIL valid_timing: %0d bad cycles, expected 0", bad_valid); end
    endtask

    task automatic test_capture;
        cs_stereo_t p;
        bit ok;
        p.left  = 24'h800001;
        p.right = 24'h7FFFFE;
        tx_q.push_back(p);
        for (int i = 0; i < 3; i++) begin
            wait_done(1, ok);
            if (model_last == p) break;
        end
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL capture_early: valid=%b, expected 0", rx_valid); end
        tick();
        checks++;
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL capture_edge: valid=%b, expected 1", rx_valid); end
        checks++;
        if (rx_left !== 24'h800001) begin errors++; $display("FAIL capture_left: got %h, expected 800001", rx_left); end
        checks++;
        if (rx_right !== 24'h7FFFFE) begin errors++; $display("FAIL capture_right: got %h, expected 7ffffe", rx_right); end
    endtask

    task automatic test_overflow;
        cs_stereo_t a, b, dropped;
        bit ok;
        a.left = 24'h000001; a.right = 24'h000002;
        b.left = 24'h000003; b.right = 24'h000004;
        wait_done(1, ok);
        for (int i = 0; i < 20; i++) tick();
        tx_q.push_back(a);
        tx_q.push_back(b);
        rx_ready = 1'b0;
        wait_done(1, ok);
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (!ok || rx_valid !== 1'b1 || rx_left !== 24'h000001 || rx_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_first: ok=%b valid=%b left=%h ovf=%b, expected 1/1/000001/0",
                     ok, rx_valid, rx_left, rx_overflow);
        end
        wait_done(1, ok);
        for (int i = 0; i < 7; i++) tick();
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        checks++;
        if (rx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: ovf=%b, expected 1", rx_overflow); end
        checks++;
        if (rx_valid !== 1'b1 || rx_left !== 24'h000003 || rx_right !== 24'h000004) begin
            errors++;
            $display("FAIL ovf_hold: valid=%b %h/%h, expected 1 000003/000004", rx_valid, rx_left, rx_right);
        end
        dropped = exp_q.pop_front();
        for (int i = 0; i < 3; i++) tick();
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        checks++;
        if (rx_overflow !== 1'b0 || rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b valid=%b, expected 0/1", rx_overflow, rx_valid);
        end
        rx_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_back_to_back;
        cs_stereo_t p;
        bit ok;
        int h0, d0, consec = 0;
        logic prev_v = 1'b0;
        wait_done(1, ok);
        for (int i = 0; i < 20; i++) tick();
        for (int i = 0; i < 4; i++) begin
            p.left  = 24'h100000 + 24'(i * 24'h010101);
            p.right = 24'hF00000 - 24'(i * 24'h001111);
            tx_q.push_back(p);
        end
        h0 = hs_count;
        d0 = done_cnt;
        for (int i = 0; i < 3000 && (done_cnt - d0) < 4; i++) begin
            tick();
            if (rx_valid && prev_v) consec++;
            prev_v = rx_valid;
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rx_valid && prev_v) consec++;
            prev_v = rx_valid;
        end
        checks++;
        if (hs_count - h0 != 4) begin errors++; $display("FAIL b2b_count: %0d handshakes, expected 4", hs_count - h0); end
        checks++;
        if (consec != 0) begin errors++; $display("FAIL b2b_single_cycle: %0d multi-cycle valids, expected 0", consec); end
        checks++;
        if (rx_overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf: ovf=%b, expected 0", rx_overflow); end
    endtask

    task automatic test_en_drop;
        cs_stereo_t p;
        bit ok;
        int h0, vseen = 0;
        p.left  = 24'hABCDEF;
        p.right = 24'h123456;
        wait_fs(ok);
        for (int i = 0; i < 320; i++) tick();
        en = 1'b0;
        h0 = hs_count;
        tick();
        checks++;
        if (cs_rx_sclk !== 1'b0 || cs_rx_lrck !== 1'b1) begin
            errors++;
            $display("FAIL en_drop_clocks: sclk=%b lrck=%b, expected 0/1", cs_rx_sclk, cs_rx_lrck);
        end
        for (int i = 0; i < 600; i++) begin
            tick();
            if (rx_valid) vseen++;
        end
        checks++;
        if (vseen != 0 || hs_count != h0) begin
            errors++;
            $display("FAIL en_drop_no_pair: valid cycles=%0d handshakes=%0d, expected 0/0", vseen, hs_count - h0);
        end
        tx_q.push_back(p);
        en = 1'b1;
        wait_done(1, ok);
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (hs_count - h0 != 1 || last_hs_l !== 24'hABCDEF || last_hs_r !== 24'h123456) begin
            errors++;
            $display("FAIL en_resume: hs=%0d pair=%h/%h, expected 1 abcdef/123456",
                     hs_count - h0, last_hs_l, last_hs_r);
        end
    endtask

    task automatic test_rst_midframe;
        cs_stereo_t dropped;
        bit ok;
        int h0;
        logic [6:0] got;
        rx_ready = 1'b0;
        for (int i = 0; i < 1200 && rx_valid !== 1'b1; i++) tick();
        checks++;
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL rst_pending: valid=%b, expected 1", rx_valid); end
        wait_fs(ok);
        for (int i = 0; i < 160; i++) tick();
        rst = 1'b1;
        tick();
        got = {cs_rx_mclk, cs_rx_sclk, cs_rx_lrck, rx_valid, rx_overflow, |rx_left, |rx_right};
        checks++;
        if (got !== 7'b0010000) begin
            errors++;
            $display("FAIL rst_midframe: mclk,sclk,lrck,valid,ovf,|l,|r = %b, expected 0010000", got);
        end
        rst = 1'b0;
        rx_ready = 1'b1;
        dropped = exp_q.pop_front();
        h0 = hs_count;
        wait_done(2, ok);
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (hs_count - h0 != 2) begin errors++; $display("FAIL rst_resume: %0d handshakes, expected 2", hs_count - h0); end
    endtask

    initial begin
        fork
            adc_model();
            monitor();
        join_none
        test_reset();
        test_clocks();
        test_capture();
        test_overflow();
        test_back_to_back();
        test_en_drop();
        test_rst_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
